seq_pattern_tx: RTL and testbench
=================================

SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

Interface
REQ-001 SHALL have parameter DIV_COUNT, default 25000000, meaning the number of clk cycles each serial bit is held (legal range 2 or more).
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: level request to send the pattern; sampled in IDLE.
REQ-005 SHALL have port pause, input, 1 bit: while 1, bit timing and shifting freeze.
REQ-006 SHALL have port data, input, 8 bits: pattern to send, MSB first.
REQ-007 SHALL have port out_bit, output, 1 bit: serial stream that feeds the sequence-detector input.
REQ-008 SHALL have port out_valid, output, 1 bit: 1 while out_bit carries a pattern bit.
REQ-009 SHALL have port busy, output, 1 bit: 1 whenever state is not IDLE.
REQ-010 SHALL have port done, output, 1 bit: one-clk pulse at the end of each frame.
REQ-011 SHALL have port seg, output, 7 bits: active-low gfedcba seven-segment display of the bits remaining.

Function
REQ-012 SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-013 IDLE with start=1 at a clk edge SHALL capture data into both the shift register and the pattern register, set the remaining count to 8, clear the tick counter, and enter SHIFT.
REQ-014 In SHIFT, out_bit SHALL equal shift register bit 7 and out_valid SHALL be 1; outside SHIFT, out_bit and out_valid SHALL be 0.
REQ-015 The tick counter SHALL increment only in SHIFT with pause=0, and SHALL wrap to 0 at DIV_COUNT-1 with a one-cycle tick.
REQ-016 On a tick with remaining count > 1, the block SHALL shift left by one (filling with 0) and decrement the remaining count.
REQ-017 On a tick with remaining count = 1, the block SHALL set the remaining count to 0 and enter DONE, unless REQ-027 applies.
REQ-018 DONE SHALL last exactly one clk with done=1, then return to IDLE.
REQ-019 If start is still 1 in the following IDLE cycle, the block SHALL retrigger, giving back-to-back frames with one IDLE cycle between them.
REQ-020 pause=1 SHALL hold the tick counter, shift register, remaining count and state.
REQ-021 Releasing pause SHALL resume counting from the held tick count, so the bit length is DIV_COUNT unpaused cycles.
REQ-022 pause SHALL have no effect in IDLE or DONE.
REQ-023 Changes to data outside the IDLE capture edge SHALL be ignored; start in SHIFT or DONE SHALL be ignored, except as in REQ-027.
REQ-024 seg SHALL show the remaining count with these encodings:
- 0 = 1000000
- 1 = 1111001
- 2 = 0100100
- 3 = 0110000
- 4 = 0011001
- 5 = 0010010
- 6 = 0000010
- 7 = 1111000
- 8 = 0000000
- any other value = 0111111 (dash)

Reset
REQ-025 rst=1 SHALL, asynchronously and including mid-frame, force:
- state = IDLE
- shift register, pattern register, tick counter and remaining count = 0
- out_bit = 0, out_valid = 0, busy = 0, done = 0
- seg = 1000000
REQ-026 After rst deasserts, the first capture SHALL occur at the first clk edge with start=1.

Configuration
REQ-027 With macro SEQ_TX_LOOP_EN defined:
- a tick with remaining count = 1 and start=1 SHALL reload the shift register from the pattern register, set the count to 8, stay in SHIFT, and pulse done for one clk.
- the looping frames SHALL contain no gap cycles.
- start=0 at that tick SHALL follow REQ-017.
REQ-028 Without SEQ_TX_LOOP_EN, the looping logic SHALL be absent, and every frame SHALL end through DONE and IDLE.

Verification (DIV_COUNT=4)
REQ-029 Single frame: rst pulse, then data=8'hB4 with start held high for one clk -> out_bit = 1,0,1,1,0,1,0,0, each bit 4 clk long; done high for exactly 1 clk, 32 clk after the capture edge; seg counts 8 down to 0; busy low after DONE.
REQ-030 Pause: data=8'hF0; assert pause for 10 clk during bit 3 -> out_bit, seg and tick counter frozen for those 10 clk; frame completes 42 clk after capture.
REQ-031 Reset mid-frame: assert rst during bit 5 of 8'hAA -> next cycle out_bit=0, out_valid=0, busy=0, seg=1000000; no done pulse.
REQ-032 Data change: change data from 8'h81 to 8'h7E during SHIFT -> transmitted bits remain 1,0,0,0,0,0,0,1.
REQ-033 Start held (macro off): start held high with data=8'h0F -> two frames separated by exactly one DONE and one IDLE cycle, 34 clk from first capture to second capture.
REQ-034 Loop (SEQ_TX_LOOP_EN defined): start held high with data=8'hC3 -> continuous stream 11000011 11000011 with no gap; done pulses every 32 clk; dropping start ends the stream after the current frame.

Source files
------------

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends an 8-bit pattern MSB first, each bit held DIV_COUNT clocks.
// Optional continuous looping while start stays high is enabled by defining SEQ_TX_LOOP_EN.
module seq_pattern_tx #(
  parameter int DIV_COUNT = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic [7:0] data,
  output logic       out_bit,
  output logic       out_valid,
  output logic       busy,
  output logic       done,
  output logic [6:0] seg,
  output logic [1:0] dbg_state
);

  localparam int TW = (DIV_COUNT > 2) ? $clog2(DIV_COUNT) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(DIV_COUNT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          r_state;
  logic [7:0]      r_shift;
  logic [TW-1:0]   r_tick;
  logic [3:0]      r_remain;
  logic            r_done;
  logic            w_tick;
`ifdef SEQ_TX_LOOP_EN
  // Only the loop reload reads the captured copy of the pattern.
  logic [7:0]      r_pattern;
`endif

  assign w_tick = (r_tick == TICK_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_shift  <= 8'd0;
      r_tick   <= '0;
      r_remain <= 4'd0;
      r_done   <= 1'b0;
`ifdef SEQ_TX_LOOP_EN
      r_pattern <= 8'd0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_shift  <= data;
`ifdef SEQ_TX_LOOP_EN
            r_pattern <= data;
`endif
            r_remain <= 4'd8;
            r_tick   <= '0;
            r_state  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // pause freezes the whole frame, so a bit lasts DIV_COUNT unpaused clocks
          if (!pause) begin
            if (w_tick) begin
              r_tick <= '0;
              if (r_remain > 4'd1) begin
                r_shift  <= {r_shift[6:0], 1'b0};
                r_remain <= r_remain - 4'd1;
              end
`ifdef SEQ_TX_LOOP_EN
              else if (start) begin
                r_shift  <= r_pattern;
                r_remain <= 4'd8;
                r_done   <= 1'b1;
              end
`endif
              else begin
                r_remain <= 4'd0;
                r_state  <= S_DONE;
                r_done   <= 1'b1;
              end
            end else begin
              r_tick <= r_tick + 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // out_valid qualifies out_bit: when high, out_bit is a pattern bit; there is no
  // back-pressure, the consumer must accept every bit while out_valid is high.
  assign out_valid = (r_state == S_SHIFT);
  assign out_bit   = out_valid & r_shift[7];
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign dbg_state = r_state;

  always_comb begin
    seg = 7'b0111111;
    case (r_remain)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      default: seg = 7'b0111111;
    endcase
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx with DIV_COUNT=4: directed frames, pause, reset, data change, start held.
module tb_seq_pattern_tx;

  localparam int DIV = 4;

  logic       clk;
  logic       rst;
  logic       start;
  logic       pause;
  logic [7:0] data;
  logic       out_bit;
  logic       out_valid;
  logic       busy;
  logic       done;
  logic [6:0] seg;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [0:0] exp_q[$];

  seq_pattern_tx #(.DIV_COUNT(DIV)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .data(data),
    .out_bit(out_bit), .out_valid(out_valid), .busy(busy), .done(done),
    .seg(seg), .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [6:0] seg_of(input int r);
    case (r)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0111111;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int e_done, input int e_busy,
                            input int e_valid, input int e_rem);
    check({tag, "_done"},  {31'b0, done},      32'(e_done));
    check({tag, "_busy"},  {31'b0, busy},      32'(e_busy));
    check({tag, "_valid"}, {31'b0, out_valid}, 32'(e_valid));
    check({tag, "_seg"},   {25'b0, seg},       {25'b0, seg_of(e_rem)});
  endtask

  // u = unpaused clocks since the capture edge
  task automatic check_frame(input string tag, input int u);
    check_outs(tag, int'(u == 32), int'(u <= 32), int'(u < 32), (u < 32) ? 8 - u / DIV : 0);
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_bits(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) exp_q.push_back(d[i]);
  endtask

  task automatic send(input logic [7:0] d);
    data  = d;
    start = 1'b1;
    push_bits(d);
    step();
  endtask

  // scoreboard: pops one expected bit per DIV unpaused valid clocks, checks every valid clock
  initial begin
    int   phase;
    logic have_bit;
    logic cur_bit;
    phase    = 0;
    have_bit = 1'b0;
    cur_bit  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        phase    = 0;
        have_bit = 1'b0;
      end else if (out_valid) begin
        if (!have_bit) begin
          check("sb_nonempty", {31'b0, exp_q.size() != 0}, 32'd1);
          if (exp_q.size() != 0) cur_bit = exp_q.pop_front();
          have_bit = 1'b1;
        end
        check("sb_bit", {31'b0, out_bit}, {31'b0, cur_bit});
        if (!pause) begin
          phase++;
          if (phase == DIV) begin
            phase    = 0;
            have_bit = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    pause = 1'b0;
    data  = 8'h00;

    // reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_bit", {31'b0, out_bit}, 32'd0);
    check_outs("rst", 0, 0, 0, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check_outs("post_rst", 0, 0, 0, 0);

    // single frame B4
    send(8'hB4);
    start = 1'b0;
    @(negedge clk);
    check_frame("b4", 0);
    for (int k = 1; k <= 36; k++) begin
      step();
      @(negedge clk);
      check_frame("b4", k);
    end

    // pause for 10 clocks inside the third bit of F0
    send(8'hF0);
    start = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      step();
      if (k == 10) pause = 1'b1;
      if (k == 20) pause = 1'b0;
      @(negedge clk);
      check_frame("pause", (k <= 10) ? k : ((k <= 20) ? 10 : k - 10));
    end

    // pause in IDLE has no effect on capture
    pause = 1'b1;
    send(8'h5A);
    start = 1'b0;
    pause = 1'b0;
    @(negedge clk);
    check_frame("idle_pause", 0);
    for (int k = 1; k <= 34; k++) begin
      step();
      @(negedge clk);
      check_frame("idle_pause", k);
    end

    // reset mid-frame during bit 5 of AA
    send(8'hAA);
    start = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      step();
      @(negedge clk);
      check_frame("aa", k);
    end
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    check("mid_rst_bit", {31'b0, out_bit}, 32'd0);
    check_outs("mid_rst", 0, 0, 0, 0);
    step();
    @(negedge clk);
    check("mid_rst2_bit", {31'b0, out_bit}, 32'd0);
    check_outs("mid_rst2", 0, 0, 0, 0);
    step();
    rst = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      step();
      @(negedge clk);
      check_outs("after_rst", 0, 0, 0, 0);
    end

    // data change during SHIFT is ignored
    send(8'h81);
    start = 1'b0;
    for (int k = 1; k <= 34; k++) begin
      step();
      if (k == 5) data = 8'h7E;
      @(negedge clk);
      check_frame("dchg", k);
    end

`ifdef SEQ_TX_LOOP_EN
    // start held: continuous C3 frames, start dropped during the second frame
    push_bits(8'hC3);
    send(8'hC3);
    for (int k = 1; k <= 70; k++) begin
      step();
      if (k == 40) start = 1'b0;
      @(negedge clk);
      check_outs("loop", int'(k == 32 || k == 64), int'(k <= 64), int'(k < 64),
                 (k < 64) ? 8 - (k % 32) / DIV : 0);
    end
`else
    // start held: two 0F frames with one DONE and one IDLE clock between them
    push_bits(8'h0F);
    send(8'h0F);
    for (int k = 1; k <= 70; k++) begin
      step();
      if (k == 34) start = 1'b0;
      @(negedge clk);
      check_outs("held", int'(k == 32 || k == 66), int'(!(k == 33 || k >= 67)),
                 int'(k < 32 || (k >= 34 && k < 66)),
                 (k < 32) ? 8 - k / DIV : ((k < 34) ? 0 : ((k < 66) ? 8 - (k - 34) / DIV : 0)));
    end
`endif

    check("q_drained", 32'(exp_q.size()), 32'd0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
